pong_match_ctrl: RTL

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve, rally, scoring, game-over. Define PONG_WIN_BY_TWO_EN to require
// a two-point lead to win (or a one-point lead once a score reaches the counter ceiling).
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE      = 11,
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned AUTO_SRV_TICKS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               serve,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               srv_l,
  output logic               srv_r,
  output logic               in_play,
  output logic               visible,
  output logic               game_over,
  output logic               winner,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score
);

  if (2 ** SCORE_W - 1 < WIN_SCORE + 1) begin : g_bad_score_w
    $error("SCORE_W too narrow for WIN_SCORE");
  end

  localparam logic [SCORE_W-1:0] ScoreMax = '1;
  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);
  localparam bit                 AutoEn   = AUTO_SRV_TICKS != 0;
  localparam int unsigned        CntW     = AutoEn ? $clog2(AUTO_SRV_TICKS + 1) : 1;
  localparam logic [CntW-1:0]    AutoLast = CntW'(AUTO_SRV_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StSrvWait, StPlay, StMissHold, StOver} state_e;

  state_e          state;
  logic            serve_side;
  logic            serve_q;
  logic [CntW-1:0] auto_cnt;
  logic            serve_req;
  logic            auto_expire;
  logic            win;
  logic            win_side;

  assign serve_req   = serve & ~serve_q;
  // Expiry is decoded from the tick that would bring the count up to AUTO_SRV_TICKS.
  assign auto_expire = AutoEn & tick & (auto_cnt == AutoLast);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == ScoreMax) ? s : s + 1'b1;
  endfunction

  always_comb begin
    win      = 1'b0;
    win_side = 1'b0;
`ifdef PONG_WIN_BY_TWO_EN
    begin
      logic [SCORE_W:0] l_ext, r_ext;
      l_ext = {1'b0, left_score};
      r_ext = {1'b0, right_score};
      if ((left_score >= WinScore && l_ext >= r_ext + (SCORE_W+1)'(2)) ||
          (left_score == ScoreMax && l_ext > r_ext)) begin
        win = 1'b1;
      end else if ((right_score >= WinScore && r_ext >= l_ext + (SCORE_W+1)'(2)) ||
                   (right_score == ScoreMax && r_ext > l_ext)) begin
        win      = 1'b1;
        win_side = 1'b1;
      end
    end
`else
    if (left_score == WinScore) begin
      win = 1'b1;
    end else if (right_score == WinScore) begin
      win      = 1'b1;
      win_side = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      left_score  <= '0;
      right_score <= '0;
      serve_side  <= 1'b0;
      auto_cnt    <= '0;
      serve_q     <= 1'b1;
      srv_l       <= 1'b0;
      srv_r       <= 1'b0;
      in_play     <= 1'b0;
      visible     <= 1'b1;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      serve_q <= serve;
      srv_l   <= 1'b0;
      srv_r   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (serve_req) begin
            state   <= StPlay;
            srv_l   <= 1'b1;
            in_play <= 1'b1;
          end
        end
        StSrvWait: begin
          if (serve_req || auto_expire) begin
            state   <= StPlay;
            srv_l   <= ~serve_side;
            srv_r   <= serve_side;
            in_play <= 1'b1;
          end else if (tick && AutoEn) begin
            auto_cnt <= auto_cnt + 1'b1;
          end
        end
        StPlay: begin
          if (miss_l || miss_r) begin
            state   <= StMissHold;
            in_play <= 1'b0;
            if (miss_r && !miss_l) begin
              left_score <= sat_inc(left_score);
              serve_side <= 1'b1;
            end else if (miss_l && !miss_r) begin
              right_score <= sat_inc(right_score);
              serve_side  <= 1'b0;
            end
          end
        end
        StMissHold: begin
          // Wait for the ball to leave the miss zone so one miss scores once.
          if (!miss_l && !miss_r) begin
            auto_cnt <= '0;
            if (win) begin
              state     <= StOver;
              game_over <= 1'b1;
              visible   <= 1'b0;
              winner    <= win_side;
            end else begin
              state <= StSrvWait;
            end
          end
        end
        StOver: begin
          if (serve_req) begin
            state       <= StIdle;
            left_score  <= '0;
            right_score <= '0;
            serve_side  <= 1'b0;
            game_over   <= 1'b0;
            visible     <= 1'b1;
            winner      <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
